pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Next-PC controller for the 5-stage MIPS pipeline.
- Owns the PC register and picks the next fetch address from these sources: sequential, branch, jump, jump-register.
- Forms jump targets by shifting the 26-bit instruction index left by 2 and concatenating the upper PC bits.
- Generates IF-stage flush and PC-write control; sits between the hazard unit, ID-stage decode and instruction memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned)
PC_W, 32, PC width (fixed 32; jump concatenation assumes 32)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hazard-unit stall: hold PC and the IF/ID register
id_pc4  input  32  PC+4 of the instruction currently in ID
br_taken  input  1  ID-stage branch resolved taken
br_off  input  32  sign-extended branch offset (words, unshifted)
jmp  input  1  ID-stage j/jal
jmp_idx  input  26  instruction index field [25:0]
jr  input  1  ID-stage jr/jalr
jr_addr  input  32  register target for jr
pc  output  32  current fetch address to instruction memory
fetch_valid  output  1  the word fetched at pc is a real instruction
if_flush  output  1  squash the IF/ID register next edge
pc_write  output  1  PC updates this cycle (= !stall in RUN/FLUSH)
align_err  output  1  sticky: a redirect target had bits[1:0] != 0

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=BOOT.
  - fetch_valid=0, if_flush=0, pc_write=0, align_err=0.
- States:
  - BOOT: one cycle after reset release. fetch_valid=0, pc_write=0, PC held. Always → RUN.
  - RUN: fetch_valid=1.
  - FLUSH: the cycle after a taken redirect. fetch_valid=1, if_flush=0. Redirects are honoured as in RUN.
- Redirect qualification:
  - Requests count only when stall=0.
  - While stall=1: pc holds, pc_write=0, requests are ignored. The ID stage re-presents them once the stall drops.
- Priority when several are asserted: jr > jmp > br_taken > sequential.
- Targets (all 32-bit, wrap modulo 2^32, no overflow flag):
  - jr: jr_addr.
  - jmp: {id_pc4[31:28], jmp_idx, 2'b00}.
  - br: id_pc4 + (br_off << 2); the discarded top bits of br_off are ignored.
  - sequential: pc + 4.
- Redirect in RUN or FLUSH (stall=0):
  - pc ← target at the next edge.
  - if_flush=1 combinationally in the same cycle, squashing the wrong-path instruction in IF.
  - state → FLUSH.
- No redirect, stall=0: pc ← pc+4; state → RUN.
- Back-to-back redirects in consecutive cycles are each honoured, with if_flush=1 in each cycle.
- Alignment: if a selected target has bits[1:0] != 0, align_err sets and stays set until reset. The PC still loads the target with bits[1:0] forced to 00.
- Wrap-around: pc=32'hFFFF_FFFC sequential → 32'h0000_0000.
- Reset mid-redirect: async reset wins immediately. pc=RESET_PC and all outputs return to reset values within the same cycle.

Optional Feature:
- Macro: PC_SEQ_DELAY_SLOT_EN.
- Defined (MIPS branch delay slot):
  - if_flush is never asserted.
  - The instruction after a branch/jump executes; the redirect still loads the target at the same edge.
  - FLUSH state is still entered for tracking, with identical outputs to RUN.
- Undefined: squash behaviour as described in Behaviour.

Test Plan:
- Reset and boot: rst_n low 3 cycles, release → pc=0, fetch_valid=0 for 1 cycle, then pc=0,4,8,... with pc_write=1.
- Jump: pc=0x0040_0010, id_pc4=0x0040_000C, jmp=1, jmp_idx=26'h010_0040 → if_flush=1 same cycle; next pc=0x0040_0100.
- Branch backward: id_pc4=0x100, br_taken=1, br_off=32'hFFFF_FFFC → next pc=0xF0; with jr=1, jr_addr=0x200 also asserted, next pc=0x200 (priority).
- Stall: stall=1 for 2 cycles with br_taken=1 → pc held, pc_write=0, if_flush=0; stall drops with br_taken=1 → redirect taken.
- Misaligned jr: jr_addr=0x0000_1002 → pc=0x1000, align_err=1 and stays set over 10 further cycles; cleared only by rst_n.
- Delay slot build (PC_SEQ_DELAY_SLOT_EN defined): repeat the jump test → if_flush stays 0, target loaded at the same edge; wrap case pc=0xFFFF_FFFC → 0x0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the 5-stage MIPS pipeline.
// Owns the PC register, arbitrates jr > jmp > branch > sequential,
// and drives IF-stage flush, PC-write and a sticky alignment error flag.
// Build option: define PC_SEQ_DELAY_SLOT_EN for MIPS branch-delay-slot
// behaviour (the wrong-path IF instruction is kept, if_flush stays low).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BOOT  | first cycle after reset release, PC held, nothing fetched
// ST_RUN   | normal fetch, PC advances by 4 or redirects
// ST_FLUSH | cycle after a taken redirect, behaves like ST_RUN
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          PC_W     = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic [PC_W-1:0] id_pc4,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_off,
   input  logic            jmp,
   input  logic [25:0]     jmp_idx,
   input  logic            jr,
   input  logic [PC_W-1:0] jr_addr,
   output logic [PC_W-1:0] pc,
   output logic            fetch_valid,
   output logic            if_flush,
   output logic            pc_write,
   output logic            align_err
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

`ifdef PC_SEQ_DELAY_SLOT_EN
   // Delay slot: the instruction already in IF is architecturally executed.
   localparam logic SQUASH_EN = 1'b0;
`else
   localparam logic SQUASH_EN = 1'b1;
`endif

   state_t          state;
   state_t          state_nxt;
   logic [PC_W-1:0] pc_nxt;
   logic [PC_W-1:0] pc_seq;
   logic [PC_W-1:0] tgt_jmp;
   logic [PC_W-1:0] tgt_br;
   logic [PC_W-1:0] tgt_sel;
   logic            req;
   logic            redirect;
   logic            unused_br_off_top;

   // Upper offset bits fall off the word-to-byte shift by design.
   assign unused_br_off_top = ^br_off[PC_W-1:PC_W-2];

   // Candidate targets and the priority pick among redirect requests.
   always_comb begin
      pc_seq  = pc + 32'd4;
      tgt_jmp = {id_pc4[PC_W-1:PC_W-4], jmp_idx, 2'b00};
      tgt_br  = id_pc4 + {br_off[PC_W-3:0], 2'b00};
      req     = jr | jmp | br_taken;
      tgt_sel = pc_seq;
      if (jr) begin
         tgt_sel = jr_addr;
      end else if (jmp) begin
         tgt_sel = tgt_jmp;
      end else if (br_taken) begin
         tgt_sel = tgt_br;
      end
   end

   // Next-state, next-PC and control outputs.
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      fetch_valid = 1'b0;
      pc_write    = 1'b0;
      if_flush    = 1'b0;
      redirect    = 1'b0;
      case (state)
         ST_BOOT: begin
            state_nxt = ST_RUN;
         end
         ST_RUN, ST_FLUSH: begin
            fetch_valid = 1'b1;
            if (!stall) begin
               pc_write = 1'b1;
               if (req) begin
                  redirect  = 1'b1;
                  if_flush  = SQUASH_EN;
                  pc_nxt    = {tgt_sel[PC_W-1:2], 2'b00};
                  state_nxt = ST_FLUSH;
               end else begin
                  pc_nxt    = pc_seq;
                  state_nxt = ST_RUN;
               end
            end
         end
         default: begin
            state_nxt = ST_BOOT;
         end
      endcase
   end

   // State and PC registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_BOOT;
         pc    <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   // Sticky flag: any taken redirect whose target is not word aligned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         align_err <= 1'b0;
      end else if (redirect && (tgt_sel[1:0] != 2'b00)) begin
         align_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural next-PC model.
module tb_pc_sequencer;

`ifdef PC_SEQ_DELAY_SLOT_EN
   localparam logic SQ = 1'b0;
`else
   localparam logic SQ = 1'b1;
`endif

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic [31:0] id_pc4;
   logic        br_taken;
   logic [31:0] br_off;
   logic        jmp;
   logic [25:0] jmp_idx;
   logic        jr;
   logic [31:0] jr_addr;
   logic [31:0] pc;
   logic        fetch_valid;
   logic        if_flush;
   logic        pc_write;
   logic        align_err;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   logic [31:0] m_pc;
   logic        m_boot;
   logic        m_align;

   pc_sequencer #(.RESET_PC(32'h0000_0000), .PC_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (stall),
      .id_pc4     (id_pc4),
      .br_taken   (br_taken),
      .br_off     (br_off),
      .jmp        (jmp),
      .jmp_idx    (jmp_idx),
      .jr         (jr),
      .jr_addr    (jr_addr),
      .pc         (pc),
      .fetch_valid(fetch_valid),
      .if_flush   (if_flush),
      .pc_write   (pc_write),
      .align_err  (align_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        s;
      logic        br;
      logic        j;
      logic        r;
      logic [31:0] ipc4;
      logic [31:0] boff;
      logic [25:0] idx;
      logic [31:0] raddr;
      logic [31:0] e_pc;
      logic        e_fv;
      logic        e_pw;
      logic        e_fl;
   } vec_t;

   vec_t tbl[12];

   function automatic vec_t mk(input logic s, br, j, r,
                               input logic [31:0] ipc4, boff,
                               input logic [25:0] idx,
                               input logic [31:0] raddr, e_pc,
                               input logic e_fv, e_pw, e_fl);
      vec_t v;
      v.s = s; v.br = br; v.j = j; v.r = r;
      v.ipc4 = ipc4; v.boff = boff; v.idx = idx; v.raddr = raddr;
      v.e_pc = e_pc; v.e_fv = e_fv; v.e_pw = e_pw; v.e_fl = e_fl;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic s, br, j, r,
                        input logic [31:0] ipc4, boff,
                        input logic [25:0] idx,
                        input logic [31:0] raddr);
      stall = s; br_taken = br; jmp = j; jr = r;
      id_pc4 = ipc4; br_off = boff; jmp_idx = idx; jr_addr = raddr;
   endtask

   // Compare all outputs against the model for the inputs now applied.
   task automatic model_check();
      logic e_fv, e_pw, red;
      e_fv = !m_boot;
      e_pw = !m_boot && !stall;
      red  = e_pw && (jr || jmp || br_taken);
      chk("pc", pc, m_pc);
      chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, e_fv});
      chk("pc_write", {31'b0, pc_write}, {31'b0, e_pw});
      chk("if_flush", {31'b0, if_flush}, {31'b0, red && SQ});
      chk("align_err", {31'b0, align_err}, {31'b0, m_align});
   endtask

   // Advance the model across the coming rising edge, then park at negedge.
   task automatic advance();
      logic [31:0] tgt;
      if (!m_boot && !stall) begin
         if (jr || jmp || br_taken) begin
            if (jr)        tgt = jr_addr;
            else if (jmp)  tgt = (id_pc4 & 32'hF000_0000) | (32'(jmp_idx) * 32'd4);
            else           tgt = id_pc4 + br_off * 32'd4;
            if (tgt % 4 != 0) m_align = 1'b1;
            m_pc = tgt - (tgt % 4);
         end else begin
            m_pc = m_pc + 32'd4;
         end
      end
      m_boot = 1'b0;
      @(negedge clk);
   endtask

   task automatic step(input logic s, br, j, r,
                       input logic [31:0] ipc4, boff,
                       input logic [25:0] idx,
                       input logic [31:0] raddr);
      drive(s, br, j, r, ipc4, boff, idx, raddr);
      #1;
      model_check();
      advance();
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0, 32'h0);
   endtask

   // Hold reset 3 cycles; returns at a negedge with rst_n just released.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0, 32'h0);
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      m_pc   = 32'h0;
      m_boot = 1'b1;
      m_align = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0, 32'h0);

      tbl[0]  = mk(0,0,0,0, 32'h0,         32'h0,         26'h0,       32'h0,         32'h0000_0000, 0,0,0);
      tbl[1]  = mk(0,0,0,0, 32'h0,         32'h0,         26'h0,       32'h0,         32'h0000_0000, 1,1,0);
      tbl[2]  = mk(0,0,0,0, 32'h0,         32'h0,         26'h0,       32'h0,         32'h0000_0004, 1,1,0);
      tbl[3]  = mk(0,0,0,1, 32'h0,         32'h0,         26'h0,       32'h0040_0010, 32'h0000_0008, 1,1,1);
      tbl[4]  = mk(0,0,1,0, 32'h0040_000C, 32'h0,         26'h010_0040, 32'h0,        32'h0040_0010, 1,1,1);
      tbl[5]  = mk(0,1,0,1, 32'h0000_0100, 32'hFFFF_FFFC, 26'h0,       32'h0000_0200, 32'h0040_0100, 1,1,1);
      tbl[6]  = mk(0,1,0,0, 32'h0000_0100, 32'hFFFF_FFFC, 26'h0,       32'h0,         32'h0000_0200, 1,1,1);
      tbl[7]  = mk(1,1,0,0, 32'h0000_0100, 32'h0000_0008, 26'h0,       32'h0,         32'h0000_00F0, 1,0,0);
      tbl[8]  = mk(1,1,0,0, 32'h0000_0100, 32'h0000_0008, 26'h0,       32'h0,         32'h0000_00F0, 1,0,0);
      tbl[9]  = mk(0,1,0,0, 32'h0000_0100, 32'h0000_0008, 26'h0,       32'h0,         32'h0000_00F0, 1,1,1);
      tbl[10] = mk(0,0,0,0, 32'h0,         32'h0,         26'h0,       32'h0,         32'h0000_0120, 1,1,0);
      tbl[11] = mk(0,0,0,0, 32'h0,         32'h0,         26'h0,       32'h0,         32'h0000_0124, 1,1,0);

      do_reset();

      // directed table
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].s, tbl[i].br, tbl[i].j, tbl[i].r,
               tbl[i].ipc4, tbl[i].boff, tbl[i].idx, tbl[i].raddr);
         #1;
         chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
         chk($sformatf("tbl%0d_fv", i), {31'b0, fetch_valid}, {31'b0, tbl[i].e_fv});
         chk($sformatf("tbl%0d_pw", i), {31'b0, pc_write}, {31'b0, tbl[i].e_pw});
         chk($sformatf("tbl%0d_fl", i), {31'b0, if_flush}, {31'b0, tbl[i].e_fl & SQ});
         model_check();
         advance();
      end
      chk("tbl_end_pc", pc, 32'h0000_0128);

      // misaligned jr: PC loads the word-aligned target, flag is sticky
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 26'h0, 32'h0000_1002);
      chk("misalign_pc", pc, 32'h0000_1000);
      for (int k = 0; k < 10; k++) begin
         idle();
         chk("align_sticky", {31'b0, align_err}, 32'h1);
      end

      // wrap-around of the sequential path
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 26'h0, 32'hFFFF_FFFC);
      chk("wrap_pre", pc, 32'hFFFF_FFFC);
      idle();
      chk("wrap_post", pc, 32'h0000_0000);

      // asynchronous reset in the middle of a redirect cycle
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 26'h0, 32'h0000_0300);
      #1;
      chk("midrst_flush_before", {31'b0, if_flush}, {31'b0, SQ});
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_pc", pc, 32'h0);
      chk("midrst_flush", {31'b0, if_flush}, 32'h0);
      chk("midrst_fv", {31'b0, fetch_valid}, 32'h0);
      chk("midrst_pw", {31'b0, pc_write}, 32'h0);
      chk("midrst_align", {31'b0, align_err}, 32'h0);
      do_reset();
      idle();
      idle();
      chk("after_rst_pc", pc, 32'h4);

      // randomized run against the model, with one reset midway
      for (int c = 0; c < 3000; c++) begin
         logic [31:0] ra;
         if (c == 1500) do_reset();
         ra = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         step($urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 7) == 0,
              $urandom_range(0, 7) == 0,
              $urandom & 32'hFFFF_FFFC,
              $urandom,
              26'($urandom),
              ra);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
